// File: rtl/image_op_seq_if.sv
// Handshake bundle for image_op_seq: command, input pixel stream and output result stream.
// The master side drives commands and input words; the slave side is the sequencer.
interface image_op_seq_if #(
  parameter int LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_last;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_len, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, out_last, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, out_last, done
  );
endinterface

// File: rtl/image_op_seq.sv
// Command-driven frame sequencer around one image_word_op datapath (darken/lighten/invert/checksum).
// Optional feature macro IMAGE_SEQ_FRAME_CNT_EN adds a 16-bit completed-command counter output.

module image_word_op (
  input  logic [1:0]  op,
  input  logic [31:0] word,
  output logic [31:0] result
);
  // Output bytes are written in reverse order: input byte i lands in the i-th byte from the top.
  always_comb begin
    result = '0;
    for (int i = 0; i < 4; i++) begin
      case (op)
        2'b00:   result[31-8*i -: 8] = word[8*i +: 8] - 8'h1F;
        2'b01:   result[31-8*i -: 8] = word[8*i +: 8] + 8'h1F;
        2'b10:   result[31-8*i -: 8] = 8'hFF - word[8*i +: 8];
        default: result[7:0]         = result[7:0] ^ word[8*i +: 8];
      endcase
    end
  end
endmodule

module image_op_seq #(
  parameter int LEN_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  image_op_seq_if.slave bus
`ifdef IMAGE_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, STREAM, EMIT} state_e;

  localparam logic [1:0] OP_CSUM = 2'b11;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [7:0]       acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;

  logic             cmd_ready;
  logic             in_ready;
  logic             cmd_fire;
  logic             in_fire;
  logic             out_fire;
  logic [7:0]       acc_nxt;
  logic [31:0]      dp_result;

  image_word_op u_word_op (
    .op     (op_q),
    .word   (bus.in_data),
    .result (dp_result)
  );

  // remain_q != 0 keeps the last pixel handshake from pulling in a word past the frame.
  assign cmd_ready = rst_n && (state_q == IDLE);
  assign in_ready  = rst_n && (state_q == STREAM) && (remain_q != '0) &&
                     ((op_q == OP_CSUM) || !out_valid_q || bus.out_ready);
  assign cmd_fire  = bus.cmd_valid && cmd_ready;
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = out_valid_q && bus.out_ready;

  assign bus.cmd_ready = cmd_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = done_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    remain_d    = remain_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    acc_nxt     = acc_q ^ dp_result[7:0];

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          op_d     = bus.cmd_op;
          remain_d = bus.cmd_len;
          acc_d    = '0;
          if (bus.cmd_len != '0) begin
            state_d = STREAM;
          end else if (bus.cmd_op == OP_CSUM) begin
            state_d     = EMIT;
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_last_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      STREAM: begin
        if (op_q == OP_CSUM) begin
          if (in_fire) begin
            acc_d    = acc_nxt;
            remain_d = remain_q - LEN_W'(1);
            if (remain_q == LEN_W'(1)) begin
              state_d     = EMIT;
              out_valid_d = 1'b1;
              out_data_d  = {24'h0, acc_nxt};
              out_last_d  = 1'b1;
            end
          end
        end else begin
          if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (out_last_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
          // A same-cycle input handshake refills the register the output just vacated.
          if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = dp_result;
            out_last_d  = (remain_q == LEN_W'(1));
            remain_d    = remain_q - LEN_W'(1);
          end
        end
      end

      EMIT: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      remain_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      remain_q    <= remain_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

`ifdef IMAGE_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts alongside the done pulse so the new value is visible in the done cycle.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (done_d) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_image_op_seq.sv
// Directed bench for image_op_seq: expected words go into a scoreboard queue as inputs are
// accepted and are compared whenever the sequencer presents an output word.
module tb_image_op_seq;
  localparam int LEN_W = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  image_op_seq_if #(.LEN_W(LEN_W)) bus ();

`ifdef IMAGE_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  image_op_seq #(.LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IMAGE_SEQ_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          frames_done = 0;
  logic [32:0] sb [$];
  logic [31:0] in_words [$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[7:0];
    b1 = w[15:8];
    b2 = w[23:16];
    b3 = w[31:24];
    case (op)
      2'b00:   return {b0 - 8'h1F, b1 - 8'h1F, b2 - 8'h1F, b3 - 8'h1F};
      2'b01:   return {b0 + 8'h1F, b1 + 8'h1F, b2 + 8'h1F, b3 + 8'h1F};
      2'b10:   return {8'hFF - b0, 8'hFF - b1, 8'hFF - b2, 8'hFF - b3};
      default: return {24'h0, b0 ^ b1 ^ b2 ^ b3};
    endcase
  endfunction

  task automatic checkFrameCnt();
`ifdef IMAGE_SEQ_FRAME_CNT_EN
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(frames_done));
`endif
  endtask

  task automatic applyStimulus(input logic [1:0] op, input int len, input bit stall);
    int          sent;
    int          cyc;
    bit          got_last;
    bit          in_fire;
    bit          out_fire;
    logic [7:0]  acc;
    logic [32:0] exp_word;
    sent     = 0;
    cyc      = 0;
    got_last = 1'b0;
    acc      = '0;

    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = LEN_W'(len);
    #1 checkOutput("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_len   = LEN_W'($urandom);

    if (op != 2'b11 && len == 0) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hDEADBEEF;
      @(negedge clk);
      checkOutput("len0_done", 32'(bus.done), 32'd1);
      checkOutput("len0_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      checkOutput("len0_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("len0_out_valid", 32'(bus.out_valid), 32'd0);
      frames_done++;
      checkFrameCnt();
      bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("len0_done_pulse", 32'(bus.done), 32'd0);
    end else begin
      if (op == 2'b11 && len == 0) sb.push_back({1'b1, 32'h0});
      while (!got_last && cyc < 200) begin
        @(negedge clk);
        checkOutput("out_valid_vs_sb", 32'(bus.out_valid), 32'(sb.size() != 0));
        if (bus.out_valid && sb.size() != 0) begin
          exp_word = sb[0];
          checkOutput("out_data", bus.out_data, exp_word[31:0]);
          checkOutput("out_last", 32'(bus.out_last), 32'(exp_word[32]));
        end
        bus.in_valid  = (sent < len);
        bus.in_data   = (sent < len) ? in_words[sent] : 32'h0;
        bus.out_ready = stall ? cyc[0] : 1'b1;
        #1;
        in_fire  = bus.in_valid && bus.in_ready;
        out_fire = bus.out_valid && bus.out_ready;
        if (out_fire) begin
          checkOutput("sb_nonempty_on_output", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_word = sb.pop_front();
            got_last = exp_word[32];
          end
        end
        if (in_fire) begin
          if (op == 2'b11) begin
            acc ^= in_words[sent][7:0] ^ in_words[sent][15:8] ^
                   in_words[sent][23:16] ^ in_words[sent][31:24];
            if (sent == len - 1) sb.push_back({1'b1, 24'h0, acc});
          end else begin
            sb.push_back({sent == len - 1, model(op, in_words[sent])});
          end
          sent++;
        end
        cyc++;
      end
      checkOutput("frame_complete", 32'(got_last), 32'd1);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      checkOutput("done_after_last", 32'(bus.done), 32'd1);
      checkOutput("cmd_ready_with_done", 32'(bus.cmd_ready), 32'd1);
      checkOutput("words_consumed", 32'(sent), 32'(len));
      checkOutput("sb_drained", 32'(sb.size()), 32'd0);
      frames_done++;
      checkFrameCnt();
      @(negedge clk);
      checkOutput("done_pulse_width", 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", bus.out_data, 32'd0);
    checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkFrameCnt();

    $display("[TB] darken len 1");
    in_words = '{32'h10203040};
    applyStimulus(2'b00, 1, 1'b0);

    $display("[TB] lighten len 2");
    in_words = '{32'hFFE10000, 32'h00000000};
    applyStimulus(2'b01, 2, 1'b0);

    $display("[TB] invert len 4 with output stalls");
    in_words = '{32'h00FF1234, 32'h89ABCDEF, 32'hFFFFFFFF, 32'h5A5A0F0F};
    applyStimulus(2'b10, 4, 1'b1);

    $display("[TB] checksum len 3");
    in_words = '{32'h01020304, 32'h10101010, 32'hA5000000};
    applyStimulus(2'b11, 3, 1'b0);

    $display("[TB] checksum len 0 and darken len 0");
    in_words.delete();
    applyStimulus(2'b11, 0, 1'b0);
    applyStimulus(2'b00, 0, 1'b0);

    $display("[TB] reset in the middle of a darken frame");
    in_words = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_len   = LEN_W'(4);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = in_words[0];
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_data   = in_words[1];
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("pending_before_reset", 32'(bus.out_valid), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    @(negedge clk);
    checkOutput("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_out_data", bus.out_data, 32'd0);
    checkOutput("midrst_out_last", 32'(bus.out_last), 32'd0);
    checkOutput("midrst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    sb.delete();
    frames_done = 0;
    @(negedge clk);
    checkOutput("midrst_after_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("midrst_after_no_done", 32'(bus.done), 32'd0);
    checkOutput("midrst_after_out_valid", 32'(bus.out_valid), 32'd0);
    checkFrameCnt();

    in_words = '{32'hCAFEF00D};
    applyStimulus(2'b00, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/image_op_seq.md
# image_op_seq

Command-driven sequencer that streams a frame of 32-bit pixel words through one `image_word_op` datapath instance. It accepts a command carrying an operation and a word count, then handles the input/output valid/ready handshakes for that many words. It registers the datapath result. For the checksum operation it XOR-accumulates across the whole frame and emits a single result word. It sits between the image DMA read stream and the write-back stream.

## Interface
- `LEN_W`, default 16: width of the frame word count.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer idle; command accepted when both are high.
- `cmd_op` input 2: 00 darken, 01 lighten, 10 invert, 11 checksum.
- `cmd_len` input LEN_W: number of input words in the frame.
- `in_valid` input 1: input word present.
- `in_ready` output 1: input word consumed when both are high.
- `in_data` input 32: input pixel word.
- `out_valid` output 1: output word present.
- `out_ready` input 1: downstream accepts.
- `out_data` output 32: result word.
- `out_last` output 1: marks the final output word of a command.
- `done` output 1: one-cycle pulse when a command completes.
- `frame_cnt` output 16: present only with `IMAGE_SEQ_FRAME_CNT_EN` (see Configuration).

## Operation
- Datapath function per word, with input bytes b0 = [7:0] through b3 = [31:24]:
  - The result is {r0, r1, r2, r3}, so r0 occupies [31:24]. This byte reversal is intentional.
  - Darken: ri = bi − 0x1F, mod 256.
  - Lighten: ri = bi + 0x1F, mod 256.
  - Invert: ri = 0xFF − bi.
  - Checksum: result = {24'h0, b0^b1^b2^b3}.
- States: IDLE, STREAM, EMIT.
- IDLE:
  - `cmd_ready` = 1.
  - On accept, latch `cmd_op` into `op_q` and `cmd_len` into `remain`. Clear the accumulator `acc`.
  - If `cmd_len` = 0: pixel ops go back to IDLE with `done` pulsed the next cycle. Checksum goes to EMIT.
  - Otherwise go to STREAM.
- STREAM, pixel ops:
  - `in_ready` = !`out_valid` | `out_ready`.
  - On an input handshake: load the output register with the datapath result and set `out_valid`. Decrement `remain`.
  - `out_last` = 1 when `remain` was 1 at that handshake.
  - When the `out_last` word handshakes on the output: pulse `done` and return to IDLE.
- STREAM, checksum:
  - `in_ready` = 1 and no output is produced.
  - On each input handshake, `acc` ^= result[7:0].
  - When the handshake with `remain` = 1 occurs, go to EMIT.
- EMIT:
  - Drive `out_valid` = 1, `out_data` = {24'h0, `acc`}, `out_last` = 1.
  - On the output handshake: pulse `done` and return to IDLE.
- Commands are never accepted outside IDLE. The command fields are ignored while busy.
- Input words beyond `cmd_len` are not consumed (`in_ready` = 0 in IDLE and EMIT).
- `remain` only decrements. It is never checked for wrap because STREAM exits at 1.

## Timing
- Reset values: `cmd_ready` = 0 during reset and 1 the first cycle after. `in_ready` = 0, `out_valid` = 0, `out_last` = 0, `out_data` = 0, `done` = 0, `acc` = 0, state = IDLE, `frame_cnt` = 0.
- Reset mid-frame: sync abort. The partial frame is discarded, no `done` pulse, and any pending output word is dropped.
- Pixel latency: output word valid one cycle after its input handshake.
- Full throughput is one word per cycle while `out_ready` is held high.
- Backpressure: `out_valid` is held and `out_data`/`out_last` stay stable until `out_ready`.
- A simultaneous input handshake and output handshake in the same cycle is legal and refills the register.
- Checksum: EMIT is entered the cycle after the last input handshake, so `out_valid` rises one cycle after that handshake.
- `done` asserts in the cycle after the final output handshake. `cmd_ready` is high in that same cycle.
- Minimum command spacing is 1 cycle in IDLE.

## Configuration
- `IMAGE_SEQ_FRAME_CNT_EN` defined:
  - Adds the `frame_cnt` output, a 16-bit count of completed commands.
  - It increments on each `done` and wraps 0xFFFF → 0.
  - Cleared by reset.
- Undefined: the `frame_cnt` port and its logic are absent. All other behaviour is identical.

## Test plan
- Darken, len 1, in 0x10203040 → `out_data` 0x211101F1, `out_last` 1, `done` one cycle after the output handshake.
- Lighten, len 2, in 0xFFE10000 then 0x00000000 → outputs 0x1F1F001E then 0x1F1F1F1F. `out_last` on the second output only.
- Invert, len 4 with `out_ready` toggled 1/0 each cycle → 0x00FF1234 gives 0xCBED00FF. No word dropped or duplicated, `out_data` stable while stalled.
- Checksum, len 3, in 0x01020304, 0x10101010, 0xA5000000 → no output during STREAM, then a single word 0x000000A1 with `out_last` 1.
- Checksum with len 0 → 0x00000000 emitted with `out_last`. Darken with len 0 → no output, `done` pulse only, no input consumed.
- `rst_n` low for 1 cycle after 2 of 4 darken words → all outputs at reset values. A new command is accepted afterwards and behaves correctly. With `IMAGE_SEQ_FRAME_CNT_EN` defined, `frame_cnt` reads 0 after the reset and 1 after the new command completes.
